// File: rtl/delay_pipe_if.sv
// Word-stream interface for delay_pipe: the input word with its qualifier, and
// the delayed word with its qualifier.
interface delay_pipe_if #(
    parameter int WIDTH = 77
);
    logic signed [WIDTH-1:0] in_data;
    logic                    in_valid;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;

    modport master (
        output in_data,
        output in_valid,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/delay_pipe.sv
// Stallable delay line for signed fixed-point words with valid tracking.
// The delay can be changed at run time; there is also a synchronous flush and a count of valid words held.
module delay_pipe #(
    parameter int FRAC_BITS = 16,
    parameter int INT_BITS  = 22,
    parameter int WIDTH     = 2*(FRAC_BITS+INT_BITS)+1,
    parameter int DEPTH     = 8,
    parameter int SEL_W     = $clog2(DEPTH+1),
    parameter int CNT_W     = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [SEL_W-1:0] dly_sel,
    delay_pipe_if.slave      pipe,
    output logic [CNT_W-1:0] count,
    output logic             sel_err
);

    localparam logic [SEL_W-1:0] DEPTH_SEL = SEL_W'(DEPTH);

    logic signed [WIDTH-1:0] data_q [DEPTH];
    logic signed [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]        vld_q;
    logic [DEPTH-1:0]        vld_d;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;
    logic                    sel_err_q;
    logic                    sel_err_d;

    logic [SEL_W-1:0]        tap;
    logic signed [WIDTH-1:0] out_data_c;
    logic                    out_valid_c;

    always_comb begin
        data_d  = data_q;
        vld_d   = vld_q;
        count_d = count_q;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_d[k] = '0;
            end
            vld_d   = '0;
            count_d = '0;
        end else if (en) begin
            data_d[0] = pipe.in_data;
            vld_d[0]  = pipe.in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k] = data_q[k-1];
                vld_d[k]  = vld_q[k-1];
            end
            // Words entering and leaving on the same edge cancel, so count stays within 0..DEPTH.
            count_d = count_q + CNT_W'(pipe.in_valid) - CNT_W'(vld_q[DEPTH-1]);
        end
    end

    always_comb begin
        sel_err_d = sel_err_q | (dly_sel > DEPTH_SEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            vld_q     <= '0;
            count_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            vld_q     <= vld_d;
            count_q   <= count_d;
            sel_err_q <= sel_err_d;
        end
    end

    // An out-of-range select saturates to the deepest stage rather than wrapping.
    always_comb begin
        tap = (dly_sel > DEPTH_SEL) ? DEPTH_SEL : dly_sel;
    end

    always_comb begin
        out_data_c  = pipe.in_data;
        out_valid_c = pipe.in_valid;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap == SEL_W'(k+1)) begin
                out_data_c  = data_q[k];
                out_valid_c = vld_q[k];
            end
        end
    end

    assign pipe.out_data  = out_data_c;
    assign pipe.out_valid = out_valid_c;
    assign count          = count_q;
    assign sel_err        = sel_err_q;

endmodule

// File: tb/tb_delay_pipe.sv
// Directed bench for delay_pipe at DEPTH=8, WIDTH=77.
// The bench checks outputs against hand-computed values.
module tb_delay_pipe;

    localparam int W     = 77;
    localparam int DEPTH = 8;
    localparam int SEL_W = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             flush;
    logic [SEL_W-1:0] dly_sel;
    logic [CNT_W-1:0] count;
    logic             sel_err;

    delay_pipe_if #(.WIDTH(W)) pif ();

    delay_pipe #(.DEPTH(DEPTH)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .flush   (flush),
        .dly_sel (dly_sel),
        .pipe    (pif.slave),
        .count   (count),
        .sel_err (sel_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic signed [W-1:0] mn;
    logic signed [W-1:0] mx;
    int sent;
    int rxn;

    initial begin
        mn = {1'b1, {(W-1){1'b0}}};
        mx = {1'b0, {(W-1){1'b1}}};

        // reset holds everything clear even with traffic applied
        rst_n = 1'b0; en = 1'b1; flush = 1'b0; dly_sel = 4'd3;
        pif.in_data = W'(123); pif.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_vld", pif.out_valid, 0);
            chk("rst_cnt", count, 0);
            chk("rst_dat", pif.out_data, 0);
        end
        chk("rst_err", sel_err, 0);
        rst_n = 1'b1; pif.in_valid = 1'b0; pif.in_data = '0;

        // latency of three enabled edges at dly_sel=3
        pif.in_data = W'(5); pif.in_valid = 1'b1;
        tick();
        pif.in_valid = 1'b0; pif.in_data = '0;
        chk("lat_cnt1", count, 1);
        chk("lat_v1", pif.out_valid, 0);
        tick();
        chk("lat_v2", pif.out_valid, 0);
        tick();
        chk("lat_v3", pif.out_valid, 1);
        chk("lat_d3", pif.out_data, 5);
        chk("lat_cnt3", count, 1);
        repeat (5) tick();
        chk("lat_cnt7", count, 1);
        tick();
        chk("lat_cnt8", count, 0);

        // stall mid-stream at full depth
        dly_sel = 4'd8; sent = 0; rxn = 0;
        for (int c = 0; c < 30; c++) begin
            en = !(c >= 5 && c < 9);
            if (en && sent < 10) begin
                pif.in_valid = 1'b1;
                pif.in_data  = W'(sent + 1);
                sent++;
            end else begin
                pif.in_valid = 1'b0;
            end
            tick();
            if (!en) chk("stall_cnt", count, 5);
            if (en && pif.out_valid) begin
                chk("stall_ord", pif.out_data, rxn + 1);
                rxn++;
            end
        end
        en = 1'b1;
        chk("stall_num", rxn, 10);
        chk("stall_end", count, 0);

        // flush a full pipe
        for (int i = 0; i < 8; i++) begin
            pif.in_valid = 1'b1; pif.in_data = W'(100 + i);
            tick();
        end
        chk("fl_full", count, 8);
        chk("fl_fv", pif.out_valid, 1);
        chk("fl_fd", pif.out_data, 100);
        flush = 1'b1; pif.in_valid = 1'b1; pif.in_data = W'(77);
        tick();
        flush = 1'b0;
        chk("fl_cnt", count, 0);
        chk("fl_vld", pif.out_valid, 0);
        pif.in_valid = 1'b1; pif.in_data = W'(51);
        tick();
        pif.in_valid = 1'b0;
        repeat (6) tick();
        chk("fl_v7", pif.out_valid, 0);
        tick();
        chk("fl_v8", pif.out_valid, 1);
        chk("fl_d8", pif.out_data, 51);

        // bypass ignores en; oversize select saturates and sets sticky error
        flush = 1'b1;
        tick();
        flush = 1'b0;
        en = 1'b0; dly_sel = 4'd0;
        pif.in_data = -W'(9); pif.in_valid = 1'b1;
        #1;
        chk("byp_d", pif.out_data, -W'(9));
        chk("byp_v", pif.out_valid, 1);
        pif.in_data = W'(1234); pif.in_valid = 1'b0;
        #1;
        chk("byp_d2", pif.out_data, 1234);
        chk("byp_v2", pif.out_valid, 0);
        chk("err_pre", sel_err, 0);
        en = 1'b1; dly_sel = 4'd12;
        pif.in_valid = 1'b1; pif.in_data = W'(66);
        tick();
        pif.in_valid = 1'b0;
        chk("err_set", sel_err, 1);
        repeat (6) tick();
        chk("sat_v7", pif.out_valid, 0);
        tick();
        chk("sat_v8", pif.out_valid, 1);
        chk("sat_d8", pif.out_data, 66);
        dly_sel = 4'd8;
        tick();
        chk("err_hold", sel_err, 1);

        // signed extremes pass bit-exact; a full pipe keeps count at DEPTH
        for (int i = 0; i < 8; i++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = (i % 2 == 0) ? mn : mx;
            tick();
        end
        chk("ext_cnt", count, 8);
        chk("ext_v0", pif.out_valid, 1);
        chk("ext_d0", pif.out_data, mn);
        pif.in_data = mx;
        tick();
        chk("ext_cnt2", count, 8);
        chk("ext_d1", pif.out_data, mx);
        pif.in_data = mn;
        tick();
        chk("ext_cnt3", count, 8);
        chk("ext_d2", pif.out_data, mn);

        // asynchronous reset mid-stream discards everything
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_v", pif.out_valid, 0);
        chk("arst_d", pif.out_data, 0);
        chk("arst_cnt", count, 0);
        chk("arst_err", sel_err, 0);
        tick();
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
